// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add/subtract, LSB first, one bit per clock,
// built around a single full-adder/full-subtractor slice.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request; sampled only while idle
//   mode         0 = a-b-bin, 1 = a+b+bin; latched on accept
//   a, b         WIDTH-bit operands; latched on accept
//   bin          borrow-in (sub) / carry-in (add); latched on accept
//   busy         high while bits are being processed
//   done         one-cycle pulse; result/cout/ovf valid from this cycle
//   result       last completed result
//   cout         borrow-out (sub) / carry-out (add) of the MSB
//   ovf          two's-complement overflow of the last completed operation
module serial_addsub #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] r_sh;
   logic             c;
   logic             mode_r;

   // single-bit slice results
   logic             ai;
   logic             bi;
   logic             x;
   logic             bit_c;
   logic             c_nxt;

   // Full-adder / full-subtractor slice on the current LSBs
   always_comb begin
      ai    = a_sh[0];
      bi    = b_sh[0];
      x     = ai ^ bi;
      bit_c = x ^ c;
      c_nxt = 1'b0;
      if (mode_r) begin
         c_nxt = (ai & bi) | (c & x);
      end else begin
         c_nxt = (~x & c) | (~ai & bi);
      end
   end

   // Control FSM, operand/result shift registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         a_sh   <= '0;
         b_sh   <= '0;
         r_sh   <= '0;
         c      <= 1'b0;
         mode_r <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  c      <= bin;
                  mode_r <= mode;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               r_sh <= {bit_c, r_sh[WIDTH-1:1]};
               c    <= c_nxt;
               if (cnt == LAST_BIT) begin
                  result <= {bit_c, r_sh[WIDTH-1:1]};
                  cout   <= c_nxt;
                  // c still holds the carry/borrow into the MSB here
                  ovf    <= c ^ c_nxt;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= FIN;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: self-checking bench for serial_addsub (WIDTH=8) with an
// arithmetic reference model.
module tb_serial_addsub;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         mode;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   int checks = 0;
   int errors = 0;

   serial_addsub #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .mode   (mode),
      .a      (a),
      .b      (b),
      .bin    (bin),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: integer arithmetic, unsigned for result/cout, signed for ovf
   task automatic ref_model(input logic m, input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic ibin, output logic [W-1:0] r, output logic co,
                            output logic ov);
      int ua, ub, us, sa, sb, ss;
      ua = int'(ia);
      ub = int'(ib);
      sa = ia[W-1] ? ua - (1 << W) : ua;
      sb = ib[W-1] ? ub - (1 << W) : ub;
      if (m) begin
         us = ua + ub + int'(ibin);
         ss = sa + sb + int'(ibin);
         co = (us >= (1 << W));
      end else begin
         us = ua - ub - int'(ibin);
         ss = sa - sb - int'(ibin);
         co = (us < 0);
      end
      r  = W'(us);
      ov = (ss > ((1 << (W - 1)) - 1)) || (ss < -(1 << (W - 1)));
   endtask

   // Drives one operation (scrambling inputs after accept) and collects observations
   task automatic do_op(input logic m, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ibin, output int lat, output int busy_cyc,
                        output logic [W-1:0] r, output logic co, output logic ov,
                        output int dones);
      mode  = m;
      a     = ia;
      b     = ib;
      bin   = ibin;
      start = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      a        = W'($urandom);
      b        = W'($urandom);
      bin      = 1'($urandom);
      mode     = 1'($urandom);
      lat      = 0;
      busy_cyc = 0;
      dones    = 0;
      while (lat < 40) begin
         if (busy) busy_cyc++;
         if (done) break;
         @(posedge clk);
         #1;
         lat++;
      end
      r  = result;
      co = cout;
      ov = ovf;
      if (done) dones++;
      @(posedge clk);
      #1;
      if (done) dones++;
   endtask

   task automatic test_reset;
      rst_n = 1'b1;
      start = 1'b0;
      mode  = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++;
      if (result !== '0) begin errors++; $display("FAIL reset_result: got %h expected 00", result); end
      checks++;
      if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b%b expected 00", cout, ovf); end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Directed vectors from the plan plus randomized operations
   task automatic test_arith;
      logic         vm [8];
      logic [W-1:0] va [8];
      logic [W-1:0] vb [8];
      logic         vbin [8];
      logic [W-1:0] r, er;
      logic         co, ov, eco, eov;
      int           lat, bc, dn;
      vm = '{0, 0, 0, 1, 1, 0, 1, 0};
      va = '{8'h05, 8'h03, 8'h80, 8'hFF, 8'h7F, 8'h00, 8'h00, 8'hAA};
      vb = '{8'h03, 8'h05, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h55};
      vbin = '{0, 0, 0, 0, 0, 1, 1, 1};
      for (int i = 0; i < 48; i++) begin
         logic m, ib2;
         logic [W-1:0] x, y;
         if (i < 8) begin
            m = vm[i]; x = va[i]; y = vb[i]; ib2 = vbin[i];
         end else begin
            m = 1'($urandom); x = W'($urandom); y = W'($urandom); ib2 = 1'($urandom);
         end
         ref_model(m, x, y, ib2, er, eco, eov);
         do_op(m, x, y, ib2, lat, bc, r, co, ov, dn);
         checks++;
         if (r !== er) begin
            errors++;
            $display("FAIL result op%0d m=%b %h,%h,%b: got %h expected %h", i, m, x, y, ib2, r, er);
         end
         checks++;
         if (co !== eco) begin
            errors++;
            $display("FAIL cout op%0d m=%b %h,%h,%b: got %b expected %b", i, m, x, y, ib2, co, eco);
         end
         checks++;
         if (ov !== eov) begin
            errors++;
            $display("FAIL ovf op%0d m=%b %h,%h,%b: got %b expected %b", i, m, x, y, ib2, ov, eov);
         end
         checks++;
         if (lat != int'(W)) begin errors++; $display("FAIL latency op%0d: got %0d expected %0d", i, lat, W); end
         checks++;
         if (bc != int'(W)) begin errors++; $display("FAIL busy_cycles op%0d: got %0d expected %0d", i, bc, W); end
         checks++;
         if (dn != 1) begin errors++; $display("FAIL done_pulses op%0d: got %0d expected 1", i, dn); end
      end
   endtask

   // start held high: 8 busy, 1 done, 1 idle, repeating
   task automatic test_back_to_back;
      logic eb, ed;
      mode  = 1'b1;
      a     = 8'h12;
      b     = 8'h34;
      bin   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 30; k++) begin
         eb = (k % 10) < 8;
         ed = (k % 10) == 8;
         checks++;
         if ({busy, done} !== {eb, ed}) begin
            errors++;
            $display("FAIL b2b cycle%0d busy/done: got %b%b expected %b%b", k, busy, done, eb, ed);
         end
         if (k == 29) start = 1'b0;
         @(posedge clk);
         #1;
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop busy: got %b expected 0", busy); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid;
      logic [W-1:0] r, er;
      logic         co, ov, eco, eov, saw_done;
      int           lat, bc, dn;
      mode  = 1'b0;
      a     = 8'h55;
      b     = 8'h0F;
      bin   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      checks++;
      if (result !== '0) begin errors++; $display("FAIL midrst_result: got %h expected 00", result); end
      checks++;
      if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL midrst_flags: got %b%b expected 00", cout, ovf); end
      saw_done = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (done) saw_done = 1'b1;
         if (k == 3) rst_n = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", saw_done); end
      ref_model(1'b0, 8'h55, 8'h0F, 1'b0, er, eco, eov);
      do_op(1'b0, 8'h55, 8'h0F, 1'b0, lat, bc, r, co, ov, dn);
      checks++;
      if ({r, co, ov} !== {er, eco, eov}) begin
         errors++;
         $display("FAIL post_reset_op: got %h/%b/%b expected %h/%b/%b", r, co, ov, er, eco, eov);
      end
      checks++;
      if (lat != int'(W)) begin errors++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, W); end
   endtask

   initial begin
      test_reset;
      test_arith;
      test_back_to_back;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
